// File: rtl/conv_sched_pkg.sv
// Shared types and job geometry for the conv engine scheduler.
package conv_sched_pkg;

   localparam int unsigned DATA_W       = 6;
   localparam int unsigned RES_W        = 12;
   localparam int unsigned FILTER_WORDS = 9;
   localparam int unsigned IMAGE_WORDS  = 49;
   localparam int unsigned RESULT_WORDS = 25;
   localparam int unsigned WCNT_W       = 6;
   localparam int unsigned RCNT_W       = 5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_F = 3'd1,
      LOAD_I = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } sched_state_t;

endpackage

// File: rtl/conv_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  id
);

   int unsigned idx;
   logic        found;

   always_comb begin
      gnt   = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!found && req[ID_W'(idx)]) begin
            found             = 1'b1;
            gnt[ID_W'(idx)]   = 1'b1;
            id                = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/conv_sched.sv
// Shares one conv engine between N_REQ requesters: grant, forward filter+image
// words, collect 25 results tagged with the requester id.
module conv_sched
   import conv_sched_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   output logic [N_REQ-1:0]    gnt,
   input  logic                word_valid,
   input  logic [DATA_W-1:0]   word_data,
   output logic                word_ready,
   output logic                eng_filter_valid,
   output logic                eng_image_valid,
   output logic [DATA_W-1:0]   eng_data,
   input  logic                eng_out_valid,
   input  logic [RES_W-1:0]    eng_out_data,
   output logic                res_valid,
   output logic [RES_W-1:0]    res_data,
   output logic [ID_W-1:0]     res_id,
   output logic                job_done,
   output logic                busy
);

   sched_state_t        state_q, state_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [ID_W-1:0]     cur_id_q, cur_id_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
   logic                eng_filter_valid_q, eng_filter_valid_d;
   logic                eng_image_valid_q, eng_image_valid_d;
   logic [DATA_W-1:0]   eng_data_q, eng_data_d;
   logic                res_valid_q, res_valid_d;
   logic [RES_W-1:0]    res_data_q, res_data_d;
   logic [ID_W-1:0]     res_id_q, res_id_d;
   logic                job_done_q, job_done_d;

   logic [N_REQ-1:0]    arb_gnt;
   logic [ID_W-1:0]     arb_id;
   logic [ID_W-1:0]     ptr_inc;
   logic                xfer;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .id  (arb_id)
   );

   assign word_ready = (state_q == LOAD_F) || (state_q == LOAD_I);
   assign busy       = (state_q != IDLE);
   assign xfer       = word_valid && word_ready;
   assign ptr_inc    = (cur_id_q == ID_W'(N_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);

   // Next-state and registered-output logic.
   always_comb begin
      state_d            = state_q;
      gnt_d              = gnt_q;
      cur_id_d           = cur_id_q;
      ptr_d              = ptr_q;
      wcnt_d             = wcnt_q;
      rcnt_d             = rcnt_q;
      eng_filter_valid_d = 1'b0;
      eng_image_valid_d  = 1'b0;
      eng_data_d         = eng_data_q;
      res_valid_d        = 1'b0;
      res_data_d         = res_data_q;
      res_id_d           = res_id_q;
      job_done_d         = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d    = arb_gnt;
               cur_id_d = arb_id;
               wcnt_d   = '0;
               rcnt_d   = '0;
               state_d  = LOAD_F;
            end
         end
         LOAD_F: begin
            if (xfer) begin
               eng_filter_valid_d = 1'b1;
               eng_data_d         = word_data;
               if (wcnt_q == WCNT_W'(FILTER_WORDS - 1)) begin
                  wcnt_d  = '0;
                  state_d = LOAD_I;
               end else begin
                  wcnt_d = wcnt_q + WCNT_W'(1);
               end
            end
         end
         LOAD_I: begin
            if (xfer) begin
               eng_image_valid_d = 1'b1;
               eng_data_d        = word_data;
               if (wcnt_q == WCNT_W'(IMAGE_WORDS - 1)) begin
                  wcnt_d  = '0;
                  state_d = DRAIN;
               end else begin
                  wcnt_d = wcnt_q + WCNT_W'(1);
               end
            end
         end
         DRAIN: begin
            if (eng_out_valid) begin
               res_valid_d = 1'b1;
               res_data_d  = eng_out_data;
               res_id_d    = cur_id_q;
               if (rcnt_q == RCNT_W'(RESULT_WORDS - 1)) begin
                  rcnt_d  = '0;
                  state_d = DONE;
               end else begin
                  rcnt_d = rcnt_q + RCNT_W'(1);
               end
            end
         end
         DONE: begin
            job_done_d = 1'b1;
            gnt_d      = '0;
            ptr_d      = ptr_inc;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= IDLE;
         gnt_q              <= '0;
         cur_id_q           <= '0;
         ptr_q              <= '0;
         wcnt_q             <= '0;
         rcnt_q             <= '0;
         eng_filter_valid_q <= 1'b0;
         eng_image_valid_q  <= 1'b0;
         eng_data_q         <= '0;
         res_valid_q        <= 1'b0;
         res_data_q         <= '0;
         res_id_q           <= '0;
         job_done_q         <= 1'b0;
      end else begin
         state_q            <= state_d;
         gnt_q              <= gnt_d;
         cur_id_q           <= cur_id_d;
         ptr_q              <= ptr_d;
         wcnt_q             <= wcnt_d;
         rcnt_q             <= rcnt_d;
         eng_filter_valid_q <= eng_filter_valid_d;
         eng_image_valid_q  <= eng_image_valid_d;
         eng_data_q         <= eng_data_d;
         res_valid_q        <= res_valid_d;
         res_data_q         <= res_data_d;
         res_id_q           <= res_id_d;
         job_done_q         <= job_done_d;
      end
   end

   assign gnt              = gnt_q;
   assign eng_filter_valid = eng_filter_valid_q;
   assign eng_image_valid  = eng_image_valid_q;
   assign eng_data         = eng_data_q;
   assign res_valid        = res_valid_q;
   assign res_data         = res_data_q;
   assign res_id           = res_id_q;
   assign job_done         = job_done_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with a behavioural conv engine on the far side.
module tb_conv_sched;
   import conv_sched_pkg::*;

   localparam int unsigned N   = 2;
   localparam int          LAT = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req;
   logic [N-1:0]      gnt;
   logic              word_valid;
   logic [DATA_W-1:0] word_data;
   logic              word_ready;
   logic              eng_filter_valid;
   logic              eng_image_valid;
   logic [DATA_W-1:0] eng_data;
   logic              eng_out_valid;
   logic [RES_W-1:0]  eng_out_data;
   logic              res_valid;
   logic [RES_W-1:0]  res_data;
   logic [0:0]        res_id;
   logic              job_done;
   logic              busy;

   always #5 clk = ~clk;

   conv_sched #(.N_REQ(N)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req              (req),
      .gnt              (gnt),
      .word_valid       (word_valid),
      .word_data        (word_data),
      .word_ready       (word_ready),
      .eng_filter_valid (eng_filter_valid),
      .eng_image_valid  (eng_image_valid),
      .eng_data         (eng_data),
      .eng_out_valid    (eng_out_valid),
      .eng_out_data     (eng_out_data),
      .res_valid        (res_valid),
      .res_data         (res_data),
      .res_id           (res_id),
      .job_done         (job_done),
      .busy             (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Engine model and output logs
   logic signed [DATA_W-1:0] f_buf [9];
   logic signed [DATA_W-1:0] img_buf [49];
   int               out_buf [25];
   int               fc = 0, ic = 0, emit_wait = 0, emit_idx = 0;
   logic             emitting = 1'b0;
   logic             m_valid = 1'b0;
   logic [RES_W-1:0] m_data = '0;
   logic             spur_valid;
   logic [RES_W-1:0] spur_data;

   logic [DATA_W-1:0] ef_log [512];
   logic [DATA_W-1:0] ei_log [512];
   logic [RES_W-1:0]  em_log [256];
   logic [RES_W-1:0]  res_log [256];
   logic [0:0]        rid_log [256];
   int ef_tot = 0, ei_tot = 0, em_tot = 0, res_tot = 0, done_tot = 0, both_tot = 0;

   assign eng_out_valid = m_valid | spur_valid;
   assign eng_out_data  = m_valid ? m_data : spur_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         fc = 0; ic = 0; emitting = 1'b0; m_valid = 1'b0; emit_idx = 0; emit_wait = 0;
      end else begin
         if (eng_filter_valid && eng_image_valid) both_tot++;
         if (res_valid && res_tot < 256) begin
            res_log[res_tot] = res_data;
            rid_log[res_tot] = res_id;
            res_tot++;
         end
         if (job_done) done_tot++;
         m_valid = 1'b0;
         if (emitting) begin
            if (emit_wait > 0) emit_wait--;
            else begin
               m_valid = 1'b1;
               m_data  = RES_W'(out_buf[emit_idx]);
               if (em_tot < 256) em_log[em_tot] = m_data;
               em_tot++;
               emit_idx++;
               if (emit_idx == 25) emitting = 1'b0;
            end
         end
         if (eng_filter_valid) begin
            if (ef_tot < 512) ef_log[ef_tot] = eng_data;
            ef_tot++;
            if (fc < 9) begin f_buf[fc] = eng_data; fc++; end
         end
         if (eng_image_valid) begin
            if (ei_tot < 512) ei_log[ei_tot] = eng_data;
            ei_tot++;
            if (ic < 49) begin
               img_buf[ic] = eng_data;
               ic++;
               if (ic == 49) begin
                  for (int r = 0; r < 5; r++)
                     for (int c = 0; c < 5; c++) begin
                        out_buf[5*r+c] = 0;
                        for (int i = 0; i < 3; i++)
                           for (int j = 0; j < 3; j++)
                              out_buf[5*r+c] += int'(f_buf[3*i+j]) * int'(img_buf[7*(r+i)+c+j]);
                     end
                  emitting = 1'b1; emit_wait = LAT; emit_idx = 0; fc = 0; ic = 0;
               end
            end
         end
      end
   end

   logic [DATA_W-1:0] words [58];

   task automatic fill_ramp();
      for (int k = 0; k < 9; k++) words[k] = DATA_W'(1);
      for (int k = 0; k < 49; k++) words[9+k] = DATA_W'(k + 1);
   endtask

   task automatic send_words(input bit stall, input bit drop_req, output bit ok);
      int  idx;
      int  cyc;
      bit  ph;
      idx = 0; cyc = 0; ph = 1'b0; ok = 1'b1;
      while (idx < 58) begin
         @(negedge clk);
         if (drop_req && idx == 19) req = '0;
         ph         = ~ph;
         word_valid = stall ? ph : 1'b1;
         word_data  = words[idx];
         #1;
         if (word_valid && word_ready) idx++;
         cyc++;
         if (cyc > 1000) begin ok = 1'b0; break; end
      end
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   task automatic run_job(input logic [N-1:0] r, input logic [N-1:0] exp_gnt,
                          input bit stall, input bit drop, input bit hold, output int rb);
      int fb, ib, eb, db, bb, cyc, errs, iderrs;
      bit ok;
      logic [0:0] exp_id;
      exp_id = (exp_gnt == 2'b10) ? 1'b1 : 1'b0;
      rb = res_tot; fb = ef_tot; ib = ei_tot; eb = em_tot; db = done_tot; bb = both_tot;
      @(negedge clk);
      req = r;
      cyc = 0;
      while (gnt == '0 && cyc < 100) begin @(negedge clk); cyc++; end
      check("gnt", gnt, exp_gnt);
      check("busy_in_job", busy, 1);
      if (!hold) req = '0;
      send_words(stall, drop, ok);
      check("load_timeout", ok, 1);
      cyc = 0;
      while (done_tot == db && cyc < 500) begin @(negedge clk); #2; cyc++; end
      check("done_timeout", cyc < 500, 1);
      check("idle_gap", {gnt, busy}, 0);
      repeat (2) @(negedge clk);
      #2;
      check("done_pulses", done_tot - db, 1);
      check("n_filter", ef_tot - fb, 9);
      check("n_image", ei_tot - ib, 49);
      check("both_high", both_tot - bb, 0);
      errs = 0;
      for (int k = 0; k < 9; k++) if (fb + k < 512 && ef_log[fb+k] !== words[k]) errs++;
      for (int k = 0; k < 49; k++) if (ib + k < 512 && ei_log[ib+k] !== words[9+k]) errs++;
      check("word_order", errs, 0);
      check("n_res", res_tot - rb, 25);
      errs = 0; iderrs = 0;
      for (int k = 0; k < 25; k++) begin
         if (rb + k < 256 && eb + k < 256) begin
            if (res_log[rb+k] !== em_log[eb+k]) errs++;
            if (rid_log[rb+k] !== exp_id) iderrs++;
         end
      end
      check("res_exact", errs, 0);
      check("res_id", iderrs, 0);
   endtask

   initial begin
      int rb, db, cyc, errs;
      bit ok;
      req = '0; word_valid = 1'b0; word_data = '0; spur_valid = 1'b0; spur_data = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outs", {gnt, word_ready, eng_filter_valid, eng_image_valid, eng_data,
                           res_valid, res_data, res_id, job_done, busy}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin: req=11 held across two jobs
      fill_ramp();
      run_job(2'b11, 2'b01, 1'b0, 1'b0, 1'b1, rb);
      check("rr0_first", res_log[rb], 81);
      run_job(2'b11, 2'b10, 1'b0, 1'b0, 1'b0, rb);
      check("rr1_first", res_log[rb], 81);
      check("rr1_second", res_log[rb+1], 90);

      // Single job, ramp image with 6-bit wrap in the last rows
      run_job(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, rb);
      check("single_first", res_log[rb], 81);
      check("single_mid", res_log[rb+12], 97);
      check("single_last", res_log[rb+24], 3889);

      // Stalled load from requester 1
      run_job(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, rb);
      check("stall_first", res_log[rb], 81);

      // Spurious engine output in IDLE
      @(negedge clk);
      spur_valid = 1'b1; spur_data = 12'd123;
      rb = res_tot;
      @(negedge clk);
      spur_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("spurious", res_tot - rb, 0);

      // Request withdrawn mid-LOAD_I
      run_job(2'b10, 2'b10, 1'b0, 1'b1, 1'b1, rb);
      check("withdrawn_first", res_log[rb], 81);

      // Signed extremes
      for (int k = 0; k < 58; k++) words[k] = DATA_W'(-32);
      run_job(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, rb);
      errs = 0;
      for (int k = 0; k < 25; k++) if (res_log[rb+k] !== 12'd1024) errs++;
      check("extreme_vals", errs, 0);

      // Reset in DRAIN after 10 results; pointer was 1 before reset
      fill_ramp();
      rb = res_tot; db = done_tot;
      @(negedge clk);
      req = 2'b10;
      cyc = 0;
      while (gnt == '0 && cyc < 100) begin @(negedge clk); cyc++; end
      req = '0;
      send_words(1'b0, 1'b0, ok);
      check("rst_load", ok, 1);
      cyc = 0;
      while (res_tot - rb < 10 && cyc < 500) begin @(negedge clk); #2; cyc++; end
      check("rst_reach10", res_tot - rb, 10);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {gnt, word_ready, eng_filter_valid, eng_image_valid, eng_data,
                             res_valid, res_data, res_id, job_done, busy}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("rst_no_done", done_tot - db, 0);
      run_job(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, rb);
      check("post_rst_first", res_log[rb], 81);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule
